// File: rtl/mux2_rr_arbiter.sv
// Two-requester valid/ready arbiter with bounded-burst round-robin grant,
// feeding a one-entry registered output channel.
module mux2_rr_arbiter #(
  parameter int WIDTH    = 8,
  parameter int HOLD_MAX = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             a_valid,
  input  logic [WIDTH-1:0] a_data,
  output logic             a_ready,
  input  logic             b_valid,
  input  logic [WIDTH-1:0] b_data,
  output logic             b_ready,
  output logic             sel,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             out_src,
  input  logic             out_ready,
  output logic             busy
);

  localparam int CNT_W = (HOLD_MAX < 1) ? 1 : $clog2(HOLD_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(HOLD_MAX);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic [1:0] {IDLE, SERVE_A, SERVE_B} state_t;

  state_t           state_p0, state_nxt, serve_x;
  logic [CNT_W-1:0] cnt_p0, cnt_nxt;
  logic             last_p0, last_nxt;
  logic             vld_p0, src_p0;
  logic [WIDTH-1:0] data_p0, mux_data;
  logic             grant, load, xfer, cnt_sat;

  assign cnt_sat  = (cnt_p0 == CNT_MAX);
  assign load     = !vld_p0 || out_ready;
  assign mux_data = grant ? b_data : a_data;

  // Grant: idle channel parks on the last winner; contention rotates once
  // the current side has used up its burst allowance.
  always_comb begin
    grant = last_p0;
    if (a_valid && !b_valid) begin
      grant = 1'b0;
    end else if (b_valid && !a_valid) begin
      grant = 1'b1;
    end else if (a_valid && b_valid) begin
      unique case (state_p0)
        SERVE_A: grant = cnt_sat;
        SERVE_B: grant = !cnt_sat;
        default: grant = 1'b0;
      endcase
    end
  end

  always_comb begin
    sel     = grant;
    a_ready = load && !rst && !grant;
    b_ready = load && !rst && grant;
    xfer    = (a_valid && a_ready) || (b_valid && b_ready);
  end

  always_comb begin
    state_nxt = state_p0;
    cnt_nxt   = cnt_p0;
    last_nxt  = last_p0;
    serve_x   = grant ? SERVE_B : SERVE_A;
    if (xfer) begin
      last_nxt = grant;
      if (state_p0 == serve_x) begin
        if (!cnt_sat) cnt_nxt = cnt_p0 + CNT_ONE;
      end else begin
        state_nxt = serve_x;
        cnt_nxt   = CNT_ONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_p0 <= IDLE;
      cnt_p0   <= '0;
      last_p0  <= 1'b0;
    end else begin
      state_p0 <= state_nxt;
      cnt_p0   <= cnt_nxt;
      last_p0  <= last_nxt;
    end
  end

  // Output register stage
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p0  <= 1'b0;
      data_p0 <= '0;
      src_p0  <= 1'b0;
    end else if (load) begin
      vld_p0 <= xfer;
      if (xfer) begin
        data_p0 <= mux_data;
        src_p0  <= grant;
      end
    end
  end

  assign out_valid = vld_p0;
  assign out_data  = data_p0;
  assign out_src   = src_p0;
  assign busy      = vld_p0;

endmodule

// File: tb/tb_mux2_rr_arbiter.sv
// Scoreboard bench for mux2_rr_arbiter: one HOLD_MAX=2 and one HOLD_MAX=1
// instance share the input stimulus; each has its own expected-beat queue.
module tb_mux2_rr_arbiter;

  localparam int W = 8;

  logic         clk, rst;
  logic         a_valid, b_valid, out_ready;
  logic [W-1:0] a_data, b_data;

  logic         a_ready, b_ready, sel, out_valid, out_src, busy;
  logic [W-1:0] out_data;
  logic         a_ready_h1, b_ready_h1, sel_h1, out_valid_h1, out_src_h1, busy_h1;
  logic [W-1:0] out_data_h1;

  int checks   = 0;
  int failures = 0;
  logic mon0 = 1'b0;
  logic mon1 = 1'b0;
  logic [W:0] sb0[$];
  logic [W:0] sb1[$];

  mux2_rr_arbiter #(.WIDTH(W), .HOLD_MAX(2)) u_dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_data(a_data), .a_ready(a_ready),
    .b_valid(b_valid), .b_data(b_data), .b_ready(b_ready),
    .sel(sel), .out_valid(out_valid), .out_data(out_data), .out_src(out_src),
    .out_ready(out_ready), .busy(busy)
  );

  mux2_rr_arbiter #(.WIDTH(W), .HOLD_MAX(1)) u_dut_h1 (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_data(a_data), .a_ready(a_ready_h1),
    .b_valid(b_valid), .b_data(b_data), .b_ready(b_ready_h1),
    .sel(sel_h1), .out_valid(out_valid_h1), .out_data(out_data_h1), .out_src(out_src_h1),
    .out_ready(out_ready), .busy(busy_h1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Sample on the falling edge; pop the scoreboard for every consumed beat.
  task automatic sample();
    logic [W:0] e;
    @(negedge clk);
    if (mon0 && out_valid && out_ready) begin
      if (sb0.size() == 0) check_eq("sb0_underflow", 32'd1, 32'd0);
      else begin
        e = sb0.pop_front();
        check_eq("beat_h2", {23'd0, out_src, out_data}, {23'd0, e});
      end
    end
    if (mon1 && out_valid_h1 && out_ready) begin
      if (sb1.size() == 0) check_eq("sb1_underflow", 32'd1, 32'd0);
      else begin
        e = sb1.pop_front();
        check_eq("beat_h1", {23'd0, out_src_h1, out_data_h1}, {23'd0, e});
      end
    end
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic push0(input logic src, input logic [W-1:0] d);
    sb0.push_back({src, d});
  endtask

  task automatic push1(input logic src, input logic [W-1:0] d);
    sb1.push_back({src, d});
  endtask

  task automatic do_reset();
    rst = 1'b1;
    sample();
    check_eq("rst_a_ready", {31'd0, a_ready}, 32'd0);
    check_eq("rst_b_ready", {31'd0, b_ready}, 32'd0);
    adv();
    rst = 1'b0;
  endtask

  task automatic idle_inputs();
    a_valid = 1'b0;
    b_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; a_valid = 1'b0; b_valid = 1'b0; out_ready = 1'b1;
    a_data = 8'h11; b_data = 8'h22;
    adv();
    do_reset();

    // Reset state
    sample();
    check_eq("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check_eq("rst_out_data", {24'd0, out_data}, 32'd0);
    check_eq("rst_out_src", {31'd0, out_src}, 32'd0);
    check_eq("rst_busy", {31'd0, busy}, 32'd0);
    check_eq("rst_sel", {31'd0, sel}, 32'd0);
    check_eq("idle_a_ready", {31'd0, a_ready}, 32'd1);
    check_eq("idle_b_ready", {31'd0, b_ready}, 32'd0);
    adv();

    // Test 1: contention, HOLD_MAX=2 -> A,A,B,B,A,A
    mon0 = 1'b1;
    push0(0, 8'h11); push0(0, 8'h11); push0(1, 8'h22);
    push0(1, 8'h22); push0(0, 8'h11); push0(0, 8'h11);
    a_valid = 1'b1; b_valid = 1'b1;
    sample();
    check_eq("t1_first_latency", {31'd0, out_valid}, 32'd0);
    adv();
    for (int i = 1; i < 6; i++) begin
      sample();
      check_eq("t1_out_valid", {31'd0, out_valid}, 32'd1);
      adv();
    end
    idle_inputs();
    sample();
    adv();
    check_eq("t1_drain", sb0.size(), 32'd0);

    // Test 2: lone B requester is never throttled
    b_valid = 1'b1; b_data = 8'h22;
    for (int i = 0; i < 6; i++) begin
      push0(1, 8'h22);
      sample();
      check_eq("t2_a_ready", {31'd0, a_ready}, 32'd0);
      check_eq("t2_sel", {31'd0, sel}, 32'd1);
      check_eq("t2_b_ready", {31'd0, b_ready}, 32'd1);
      adv();
    end
    idle_inputs();
    sample();
    adv();
    check_eq("t2_drain", sb0.size(), 32'd0);

    // Test 3: stall holds the captured beat and the round-robin position
    do_reset();
    push0(0, 8'h11); push0(0, 8'h11); push0(1, 8'h22);
    push0(1, 8'h22); push0(0, 8'h11); push0(0, 8'h11);
    a_valid = 1'b1; b_valid = 1'b1; out_ready = 1'b1;
    sample();
    adv();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      sample();
      check_eq("t3_hold_valid", {31'd0, out_valid}, 32'd1);
      check_eq("t3_hold_data", {24'd0, out_data}, 32'h11);
      check_eq("t3_a_ready", {31'd0, a_ready}, 32'd0);
      check_eq("t3_b_ready", {31'd0, b_ready}, 32'd0);
      adv();
    end
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      sample();
      adv();
    end
    idle_inputs();
    sample();
    adv();
    check_eq("t3_drain", sb0.size(), 32'd0);

    // Test 4: reset mid-operation drops the held beat and returns to IDLE
    mon0 = 1'b0;
    a_valid = 1'b1; b_valid = 1'b1; out_ready = 1'b0;
    sample();
    adv();
    rst = 1'b1;
    sample();
    check_eq("t4_pre_valid", {31'd0, out_valid}, 32'd1);
    check_eq("t4_rst_a_ready", {31'd0, a_ready}, 32'd0);
    check_eq("t4_rst_b_ready", {31'd0, b_ready}, 32'd0);
    adv();
    rst = 1'b0; out_ready = 1'b1;
    sample();
    check_eq("t4_out_valid", {31'd0, out_valid}, 32'd0);
    check_eq("t4_out_data", {24'd0, out_data}, 32'd0);
    check_eq("t4_out_src", {31'd0, out_src}, 32'd0);
    check_eq("t4_sel_first", {31'd0, sel}, 32'd0);
    check_eq("t4_a_ready", {31'd0, a_ready}, 32'd1);
    adv();
    sample();
    check_eq("t4_beat", {23'd0, out_src, out_data}, 32'h011);
    idle_inputs();
    adv();
    sample();
    adv();

    // Test 5: HOLD_MAX=1 strict alternation, then lone A
    do_reset();
    mon1 = 1'b1;
    a_data = 8'h11; b_data = 8'h22;
    push1(0, 8'h11); push1(1, 8'h22); push1(0, 8'h11); push1(1, 8'h22);
    a_valid = 1'b1; b_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      sample();
      adv();
    end
    b_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      a_data = 8'h30 + 8'(i);
      push1(0, 8'h30 + 8'(i));
      sample();
      check_eq("t5_a_ready", {31'd0, a_ready_h1}, 32'd1);
      adv();
    end
    idle_inputs();
    sample();
    adv();
    check_eq("t5_drain", sb1.size(), 32'd0);
    mon1 = 1'b0;

    // Test 6: idle/A-only alternation after a B beat; idle grant parks on A
    do_reset();
    mon0 = 1'b1;
    b_valid = 1'b1; b_data = 8'h5b;
    push0(1, 8'h5b);
    sample();
    adv();
    b_valid = 1'b0;
    for (int t = 1; t <= 8; t++) begin
      if (t % 2 == 1) begin
        a_valid = 1'b1;
        a_data  = 8'h40 + 8'(t);
        push0(0, 8'h40 + 8'(t));
      end else begin
        a_valid = 1'b0;
      end
      sample();
      check_eq("t6_out_valid", {31'd0, out_valid}, (t == 1 || t % 2 == 0) ? 32'd1 : 32'd0);
      if (t % 2 == 0) check_eq("t6_idle_sel", {31'd0, sel}, 32'd0);
      adv();
    end
    idle_inputs();
    sample();
    adv();
    check_eq("t6_drain", sb0.size(), 32'd0);
    mon0 = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
